// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns level-held datapath load/store strobes into
// single RAM transactions and stalls the CPU until done. Optional: MEM_ALIGN_CHECK_EN.
module dmem_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  cpu_rst,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_dout,
    output logic [31:0]           mem_din,
    output logic                  stall,
    output logic                  align_err,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // A write completes WR_LATENCY cycles after the ram_we cycle, which itself counts,
    // so the wait phase is one cycle shorter than for reads.
    localparam logic [2:0] RD_CNT = 3'(RD_LATENCY);
    localparam logic [2:0] WR_CNT = 3'(WR_LATENCY - 1);

    state_t     state;
    logic       is_wr;
    logic [2:0] cnt;
    logic       align_err_q;
    logic       misaligned;
    logic       req;
    logic       unused_addr_bits;

    assign req = mem_ren | mem_wen;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (mem_addr[1:0] != 2'b00);
    assign align_err  = align_err_q;
`else
    assign misaligned = 1'b0;
    assign align_err  = 1'b0;
`endif

    assign stall = ~cpu_rst & ((state == IDLE) ? req : (state != DONE));

    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            state       <= IDLE;
            is_wr       <= 1'b0;
            cnt         <= 3'd0;
            mem_din     <= 32'd0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= 32'd0;
            align_err_q <= 1'b0;
        end else begin
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            align_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (misaligned) begin
                            align_err_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            is_wr     <= mem_wen;
                            ram_addr  <= mem_addr[ADDR_WIDTH+1:2];
                            ram_wdata <= mem_dout;
                            ram_en    <= 1'b1;
                            ram_we    <= mem_wen;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (is_wr && WR_CNT == 3'd0) begin
                        state <= DONE;
                    end else begin
                        cnt   <= is_wr ? WR_CNT : RD_CNT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (!is_wr) mem_din <= ram_rdata;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: transaction-level model of stall length, RAM strobes
// and read data, with a latency-accurate RAM model and one per-cycle compare process.
module tb_dmem_ctrl;
    localparam int AW = 10;
    localparam int RD = 2;
    localparam int WR = 1;

    logic          clk = 1'b0;
    logic          cpu_rst;
    logic          mem_ren, mem_wen;
    logic [31:0]   mem_addr, mem_dout, mem_din;
    logic          stall, align_err, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    dmem_ctrl #(.ADDR_WIDTH(AW), .RD_LATENCY(RD), .WR_LATENCY(WR)) dut (
        .clk(clk), .cpu_rst(cpu_rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din), .stall(stall),
        .align_err(align_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // RAM model: data for a read issued in cycle c is presented during cycle c+RD.
    bit [31:0]   ram_mem [1<<AW];
    int          cyc = 0;
    int          due = -1;
    logic [31:0] pdata = 32'd0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) begin
            due   <= cyc + RD;
            pdata <= ram_mem[ram_addr];
        end
        if (RD == 1 && ram_en && !ram_we) ram_rdata <= ram_mem[ram_addr];
        else ram_rdata <= (cyc + 1 == due) ? pdata : $urandom;
    end

    // Reference model state and per-cycle expectations.
    bit [31:0]     model_mem [1<<AW];
    logic [31:0]   cur_din;
    logic          chk_on = 1'b0;
    logic          exp_stall, exp_en, exp_we, exp_aerr;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wdata, exp_din;
    int            obs_stall, obs_en, obs_we;
    logic [AW-1:0] obs_addr;

    always @(negedge clk) begin
        if (chk_on) begin
            check("stall", {31'd0, stall}, {31'd0, exp_stall});
            check("ram_en", {31'd0, ram_en}, {31'd0, exp_en});
            check("ram_we", {31'd0, ram_we}, {31'd0, exp_we});
            check("align_err", {31'd0, align_err}, {31'd0, exp_aerr});
            check("mem_din", mem_din, exp_din);
            if (exp_en) begin
                check("ram_addr", {22'd0, ram_addr}, {22'd0, exp_addr});
                check("ram_wdata", ram_wdata, exp_wdata);
            end
            if (stall) obs_stall++;
            if (ram_en) begin
                obs_en++;
                obs_addr = ram_addr;
                if (ram_we) obs_we++;
            end
        end
    end

    task automatic txn(input bit ren, input bit wen, input logic [31:0] addr,
                       input logic [31:0] data);
        bit            req = ren | wen;
        bit            mis;
        int            n;
        logic [AW-1:0] wa = addr[AW+1:2];
        logic [31:0]   new_din = cur_din;
`ifdef MEM_ALIGN_CHECK_EN
        mis = req && (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        n = !req ? 0 : mis ? 1 : wen ? WR + 1 : RD + 2;
        if (req && !wen && !mis) new_din = model_mem[wa];
        for (int k = 0; k <= n; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = data;
                obs_stall = 0; obs_en = 0; obs_we = 0;
            end else if (k < n) begin
                mem_addr = $urandom; mem_dout = $urandom;
            end
            exp_stall = (k < n);
            exp_en    = req && !mis && (k == 1);
            exp_we    = exp_en && wen;
            exp_addr  = wa;
            exp_wdata = data;
            exp_aerr  = mis && (k == n);
            exp_din   = (k == n) ? new_din : cur_din;
        end
        if (req && wen && !mis) model_mem[wa] = data;
        cur_din = new_din;
        @(negedge clk); #1;
    endtask

    initial begin
        int r;
        logic [31:0] a;
        cpu_rst = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h10; mem_dout = 32'h0;
        cur_din = 32'd0;
        @(posedge clk); #1;
        exp_stall = 0; exp_en = 0; exp_we = 0; exp_aerr = 0; exp_din = 32'd0;
        exp_addr = '0; exp_wdata = 32'd0;
        chk_on = 1'b1;
        @(negedge clk); #1;
        check("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        @(posedge clk); #1; mem_ren = 1'b0;
        @(posedge clk); #1; cpu_rst = 1'b0;

        txn(0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
        check("wr_stall_cycles", obs_stall, 2);
        check("wr_ram_addr", {22'd0, obs_addr}, 32'h4);
        check("wr_issue_count", obs_we, 1);

        txn(1, 0, 32'h0000_0010, 32'h0);
        check("rd_stall_cycles", obs_stall, 4);
        check("rd_data", mem_din, 32'hDEAD_BEEF);

        txn(1, 1, 32'h0000_0020, 32'h1234_5678);
        check("both_is_write", obs_we, 1);
        check("both_din_kept", mem_din, 32'hDEAD_BEEF);

        txn(0, 1, 32'hFFFF_F010, 32'hA5A5_0001);
        check("wrap_ram_addr", {22'd0, obs_addr}, 32'h4);
        txn(1, 0, 32'h0000_0010, 32'h0);
        check("wrap_rd_data", mem_din, 32'hA5A5_0001);

        // Reset during the WAIT phase of a read: the pending data must never land.
        @(posedge clk); #1;
        mem_ren = 1; mem_wen = 0; mem_addr = 32'h0000_0020;
        exp_stall = 1; exp_en = 0; exp_we = 0; exp_aerr = 0; exp_din = cur_din;
        @(posedge clk); #1;
        exp_en = 1; exp_addr = 10'h8; exp_wdata = mem_dout;
        @(posedge clk); #1;
        cpu_rst = 1; exp_stall = 0; exp_en = 0;
        @(posedge clk); #1;
        cpu_rst = 0; mem_ren = 0; exp_din = 32'd0; cur_din = 32'd0;
        @(negedge clk); #1;
        check("rst_wait_din", mem_din, 32'd0);

        txn(1, 0, 32'h0000_0012, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_no_ram_en", obs_en, 0);
        check("mis_stall_cycles", obs_stall, 1);
        check("mis_din_kept", mem_din, 32'd0);
`else
        check("unaligned_rd_data", mem_din, 32'hA5A5_0001);
        check("unaligned_ram_addr", {22'd0, obs_addr}, 32'h4);
`endif

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[AW+1:2] = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            txn(r >= 1 && r <= 4 || r == 9, r >= 5, a, $urandom);
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
